// File: rtl/dma_frame_scheduler_pkg.sv
// ============================================================================
// dma_frame_scheduler_pkg : shared types and constants for the frame scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package dma_frame_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_PRE_RST    = 3'd1,
      S_LAUNCH     = 3'd2,
      S_WAIT_START = 3'd3,
      S_WAIT_DONE  = 3'd4,
      S_NEXT       = 3'd5,
      S_DONE       = 3'd6,
      S_ERR        = 3'd7
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int ERR_RD = 0;
   localparam int ERR_WR = 1;
   localparam int ERR_TO = 2;

   localparam int WD_W = 24;

   typedef struct packed {
      logic        rd_en;
      logic        wr_en;
      logic [31:0] src_base0;
      logic [31:0] src_base1;
      logic [31:0] dst_base0;
      logic [31:0] dst_base1;
      logic [15:0] frame_count;
   } frame_cfg_t;

   function automatic logic resp_is_err(input logic [1:0] resp);
      logic err;
      case (resp)
         RESP_OKAY:                err = 1'b0;
         RESP_SLVERR, RESP_DECERR: err = 1'b1;
         default:                  err = 1'b0;
      endcase
      return err;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dma_frame_scheduler_if.sv
// ============================================================================
// dma_frame_scheduler_if : control/status link between scheduler and DMA engine
// Revision: 1.0
// ============================================================================
`default_nettype none

interface dma_frame_scheduler_if;
   logic        dma_resetn;
   logic        read_active;
   logic        write_active;
   logic [31:0] read_address;
   logic [31:0] write_address;
   logic        read_idle;
   logic        write_idle;
   logic [3:0]  rw_resp;

   modport master (
      output dma_resetn, read_active, write_active, read_address, write_address,
      input  read_idle, write_idle, rw_resp
   );

   modport slave (
      input  dma_resetn, read_active, write_active, read_address, write_address,
      output read_idle, write_idle, rw_resp
   );
endinterface

`default_nettype wire

// File: rtl/dma_frame_scheduler_watchdog.sv
// ============================================================================
// dma_watchdog : clearable saturating cycle counter with limit-reached flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_watchdog
   import dma_frame_scheduler_pkg::*;
#(
   parameter int WIDTH = WD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] limit,
   output logic             expire
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !(&cnt_q))
         cnt_d = cnt_q + WIDTH'(1);
   end

   // High on the enabled cycle whose count brings the total to the limit
   assign expire = en && (({1'b0, cnt_q} + (WIDTH+1)'(1)) >= {1'b0, limit});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

`default_nettype wire

// File: rtl/dma_frame_scheduler.sv
// ============================================================================
// dma_frame_scheduler : per-frame reset/launch/wait sequencer for the ACP DMA
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_frame_scheduler
   import dma_frame_scheduler_pkg::*;
#(
   parameter int              RST_CYCLES = 2,
   parameter logic [WD_W-1:0] TIMEOUT    = 24'd4_000_000,
   parameter int              START_WIN  = 4
) (
   input  logic                  m_axi_acp_aclk,
   input  logic                  axi_resetn,
   input  logic                  cfg_rd_en,
   input  logic                  cfg_wr_en,
   input  logic [31:0]           cfg_src_base0,
   input  logic [31:0]           cfg_src_base1,
   input  logic [31:0]           cfg_dst_base0,
   input  logic [31:0]           cfg_dst_base1,
   input  logic [15:0]           cfg_frame_count,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done_irq,
   output logic                  err_irq,
   output logic [15:0]           frames_done,
   output logic [2:0]            err_code,
   dma_frame_scheduler_if.master dma
);

   localparam logic [15:0]     RST_LAST    = 16'(RST_CYCLES - 1);
   localparam logic [WD_W-1:0] START_LIMIT = WD_W'(START_WIN);

   state_e      state_q, state_d;
   frame_cfg_t  cfg_q, cfg_d;
   logic        buf_sel_q, buf_sel_d;
   logic [15:0] rst_cnt_q, rst_cnt_d;
   logic        abort_pend_q, abort_pend_d;
   logic        busy_q, busy_d;
   logic        done_irq_q, done_irq_d;
   logic        err_irq_q, err_irq_d;
   logic [15:0] frames_done_q, frames_done_d;
   logic [2:0]  err_code_q, err_code_d;
   logic        dma_resetn_q, dma_resetn_d;
   logic        read_active_q, read_active_d;
   logic        write_active_q, write_active_d;
   logic [31:0] read_address_q, read_address_d;
   logic [31:0] write_address_q, write_address_d;

   logic all_idle, all_started;
   logic wd_clr, start_expire, frame_expire;

   assign all_idle    = (!cfg_q.rd_en || dma.read_idle)  && (!cfg_q.wr_en || dma.write_idle);
   assign all_started = (!cfg_q.rd_en || !dma.read_idle) && (!cfg_q.wr_en || !dma.write_idle);

   // Both windows restart on the way into WAIT_START, which is only reached from LAUNCH
   assign wd_clr = (state_q == S_LAUNCH);

   dma_watchdog #(.WIDTH(WD_W)) u_start_wd (
      .clk    (m_axi_acp_aclk),
      .rst_n  (axi_resetn),
      .clr    (wd_clr),
      .en     (state_q == S_WAIT_START),
      .limit  (START_LIMIT),
      .expire (start_expire)
   );

   dma_watchdog #(.WIDTH(WD_W)) u_frame_wd (
      .clk    (m_axi_acp_aclk),
      .rst_n  (axi_resetn),
      .clr    (wd_clr),
      .en     (state_q == S_WAIT_DONE),
      .limit  (TIMEOUT),
      .expire (frame_expire)
   );

   always_comb begin
      state_d         = state_q;
      cfg_d           = cfg_q;
      buf_sel_d       = buf_sel_q;
      rst_cnt_d       = rst_cnt_q;
      abort_pend_d    = abort_pend_q;
      busy_d          = busy_q;
      done_irq_d      = 1'b0;
      err_irq_d       = 1'b0;
      frames_done_d   = frames_done_q;
      err_code_d      = err_code_q;
      dma_resetn_d    = dma_resetn_q;
      read_active_d   = 1'b0;
      write_active_d  = 1'b0;
      read_address_d  = read_address_q;
      write_address_d = write_address_q;

      if (abort && busy_q)
         abort_pend_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            dma_resetn_d = 1'b1;
            busy_d       = 1'b0;
            if (start && (cfg_rd_en || cfg_wr_en)) begin
               cfg_d         = '{rd_en: cfg_rd_en, wr_en: cfg_wr_en,
                                 src_base0: cfg_src_base0, src_base1: cfg_src_base1,
                                 dst_base0: cfg_dst_base0, dst_base1: cfg_dst_base1,
                                 frame_count: cfg_frame_count};
               frames_done_d = '0;
               err_code_d    = '0;
               buf_sel_d     = 1'b0;
               abort_pend_d  = 1'b0;
               busy_d        = 1'b1;
               dma_resetn_d  = 1'b0;
               rst_cnt_d     = '0;
               state_d       = S_PRE_RST;
            end
         end
         S_PRE_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               dma_resetn_d    = 1'b1;
               read_active_d   = cfg_q.rd_en;
               write_active_d  = cfg_q.wr_en;
               read_address_d  = buf_sel_q ? cfg_q.src_base1 : cfg_q.src_base0;
               write_address_d = buf_sel_q ? cfg_q.dst_base1 : cfg_q.dst_base0;
               state_d         = S_LAUNCH;
            end else begin
               rst_cnt_d = rst_cnt_q + 16'd1;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (all_started) begin
               state_d = S_WAIT_DONE;
            end else if (start_expire) begin
               err_code_d[ERR_TO] = 1'b1;
               err_irq_d          = 1'b1;
               state_d            = S_ERR;
            end
         end
         S_WAIT_DONE: begin
            if (cfg_q.rd_en && resp_is_err(dma.rw_resp[3:2]))
               err_code_d[ERR_RD] = 1'b1;
            if (cfg_q.wr_en && resp_is_err(dma.rw_resp[1:0]))
               err_code_d[ERR_WR] = 1'b1;
            // Uses this cycle's responses so a late error still beats completion
            if (frame_expire) begin
               err_code_d[ERR_TO] = 1'b1;
               err_irq_d          = 1'b1;
               state_d            = S_ERR;
            end else if (all_idle) begin
               if (err_code_d != 3'b000) begin
                  err_irq_d = 1'b1;
                  state_d   = S_ERR;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            frames_done_d = frames_done_q + 16'd1;
            buf_sel_d     = !buf_sel_q;
            if (abort_pend_q ||
                ((cfg_q.frame_count != 16'd0) && ((frames_done_q + 16'd1) == cfg_q.frame_count))) begin
               done_irq_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               dma_resetn_d = 1'b0;
               rst_cnt_d    = '0;
               state_d      = S_PRE_RST;
            end
         end
         S_DONE, S_ERR: begin
            busy_d       = 1'b0;
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q         <= S_IDLE;
         cfg_q           <= '0;
         buf_sel_q       <= 1'b0;
         rst_cnt_q       <= '0;
         abort_pend_q    <= 1'b0;
         busy_q          <= 1'b0;
         done_irq_q      <= 1'b0;
         err_irq_q       <= 1'b0;
         frames_done_q   <= '0;
         err_code_q      <= '0;
         dma_resetn_q    <= 1'b0;
         read_active_q   <= 1'b0;
         write_active_q  <= 1'b0;
         read_address_q  <= '0;
         write_address_q <= '0;
      end else begin
         state_q         <= state_d;
         cfg_q           <= cfg_d;
         buf_sel_q       <= buf_sel_d;
         rst_cnt_q       <= rst_cnt_d;
         abort_pend_q    <= abort_pend_d;
         busy_q          <= busy_d;
         done_irq_q      <= done_irq_d;
         err_irq_q       <= err_irq_d;
         frames_done_q   <= frames_done_d;
         err_code_q      <= err_code_d;
         dma_resetn_q    <= dma_resetn_d;
         read_active_q   <= read_active_d;
         write_active_q  <= write_active_d;
         read_address_q  <= read_address_d;
         write_address_q <= write_address_d;
      end
   end

   assign busy              = busy_q;
   assign done_irq          = done_irq_q;
   assign err_irq           = err_irq_q;
   assign frames_done       = frames_done_q;
   assign err_code          = err_code_q;
   assign dma.dma_resetn    = dma_resetn_q;
   assign dma.read_active   = read_active_q;
   assign dma.write_active  = write_active_q;
   assign dma.read_address  = read_address_q;
   assign dma.write_address = write_address_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_frame_scheduler.sv
// ============================================================================
// tb_dma_frame_scheduler : directed + randomized runs against a frame-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_frame_scheduler;

   localparam int          RST_CYCLES = 2;
   localparam logic [23:0] TIMEOUT    = 24'd50;
   localparam int          START_WIN  = 4;

   logic        clk = 1'b0;
   logic        axi_resetn;
   logic        cfg_rd_en, cfg_wr_en;
   logic [31:0] cfg_src_base0, cfg_src_base1, cfg_dst_base0, cfg_dst_base1;
   logic [15:0] cfg_frame_count;
   logic        start, abort;
   logic        busy, done_irq, err_irq;
   logic [15:0] frames_done;
   logic [2:0]  err_code;

   dma_frame_scheduler_if dif ();

   dma_frame_scheduler #(
      .RST_CYCLES (RST_CYCLES),
      .TIMEOUT    (TIMEOUT),
      .START_WIN  (START_WIN)
   ) dut (
      .m_axi_acp_aclk  (clk),
      .axi_resetn      (axi_resetn),
      .cfg_rd_en       (cfg_rd_en),
      .cfg_wr_en       (cfg_wr_en),
      .cfg_src_base0   (cfg_src_base0),
      .cfg_src_base1   (cfg_src_base1),
      .cfg_dst_base0   (cfg_dst_base0),
      .cfg_dst_base1   (cfg_dst_base1),
      .cfg_frame_count (cfg_frame_count),
      .start           (start),
      .abort           (abort),
      .busy            (busy),
      .done_irq        (done_irq),
      .err_irq         (err_irq),
      .frames_done     (frames_done),
      .err_code        (err_code),
      .dma             (dif)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // DMA behaviour and observation state
   bit          never_fall, never_rise;
   bit          pend, pend_rd, pend_wr;
   int          busy_left;
   int          inj_frame, abort_frame;
   logic [3:0]  inj_val;
   int          n_launch, n_rd, n_wr, n_rstp, n_done, n_err;
   int          first_launch_cyc, launch_cyc, irq_cyc;
   logic        prev_rstn;
   logic [31:0] rd_addr_q[$];
   logic [31:0] wr_addr_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      n_launch = 0; n_rd = 0; n_wr = 0; n_rstp = 0; n_done = 0; n_err = 0;
      first_launch_cyc = -1; launch_cyc = -1; irq_cyc = -1;
      rd_addr_q.delete();
      wr_addr_q.delete();
   endtask

   // One clock: sample outputs 1 time unit after the edge, then update the DMA stand-in
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      start       = 1'b0;
      abort       = 1'b0;
      dif.rw_resp = 4'b0000;
      if (!dif.dma_resetn) begin
         dif.read_idle  = 1'b1;
         dif.write_idle = 1'b1;
         busy_left      = 0;
         pend           = 1'b0;
      end else begin
         if (busy_left > 0) begin
            busy_left--;
            if (n_launch - 1 == inj_frame && busy_left == 2) dif.rw_resp = inj_val;
            if (n_launch - 1 == abort_frame && busy_left == 3) abort = 1'b1;
            if (busy_left == 0) begin
               dif.read_idle  = 1'b1;
               dif.write_idle = 1'b1;
            end
         end
         if (pend) begin
            pend = 1'b0;
            if (!never_fall) begin
               dif.read_idle  = !pend_rd;
               dif.write_idle = !pend_wr;
               busy_left      = never_rise ? 1000000 : $urandom_range(40, 6);
            end
         end
      end
      if (dif.read_active || dif.write_active) begin
         n_launch++;
         launch_cyc = cyc;
         if (first_launch_cyc < 0) first_launch_cyc = cyc;
         pend    = 1'b1;
         pend_rd = dif.read_active;
         pend_wr = dif.write_active;
      end
      if (dif.read_active) begin n_rd++; rd_addr_q.push_back(dif.read_address); end
      if (dif.write_active) begin n_wr++; wr_addr_q.push_back(dif.write_address); end
      if (!dif.dma_resetn && prev_rstn) n_rstp++;
      prev_rstn = dif.dma_resetn;
      if (done_irq) begin n_done++; irq_cyc = cyc; end
      if (err_irq)  begin n_err++;  irq_cyc = cyc; end
   endtask

   task automatic run(input bit rd, input bit wr, input int count, input int abort_f,
                      input int inj_f, input logic [3:0] inj_v, input bit nf, input bit nr,
                      input string tag);
      logic [31:0] s0, s1, d0, d1;
      int          s_cyc, exp_f, exp_launch;
      logic [2:0]  exp_code;
      bit          finished;
      s0 = $urandom; s1 = $urandom; d0 = $urandom; d1 = $urandom;
      cfg_rd_en = rd; cfg_wr_en = wr;
      cfg_src_base0 = s0; cfg_src_base1 = s1; cfg_dst_base0 = d0; cfg_dst_base1 = d1;
      cfg_frame_count = 16'(count);
      never_fall = nf; never_rise = nr;
      inj_frame = inj_f; inj_val = inj_v; abort_frame = abort_f;
      clear_obs();
      s_cyc = cyc;
      start = 1'b1;
      tick();
      chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
      chk({tag, "_rstn_low"},  32'(dif.dma_resetn), 32'd0);
      // Scramble live config: the run must use the snapshot
      cfg_src_base0 = ~s0; cfg_src_base1 = ~s1; cfg_dst_base0 = ~d0; cfg_dst_base1 = ~d1;
      cfg_frame_count = 16'(count + 5);
      finished = 1'b0;
      for (int i = 0; i < 3000 && !finished; i++) begin
         tick();
         if (i == 2) start = 1'b1;
         finished = (n_done + n_err) > 0;
      end
      chk({tag, "_finished"}, 32'(finished), 32'd1);
      tick();
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);

      // Frame-level expectation
      exp_code = 3'b000;
      if (nf || nr) begin
         exp_f    = 0;
         exp_code = 3'b100;
      end else begin
         exp_f = (count == 0) ? 32'h4000_0000 : count;
         if (abort_f >= 0 && abort_f + 1 < exp_f) exp_f = abort_f + 1;
         if (inj_f >= 0 && inj_f < exp_f) begin
            exp_code = {1'b0, wr & inj_v[1], rd & inj_v[3]};
            if (exp_code != 3'b000) exp_f = inj_f;
         end
      end
      exp_launch = exp_f + ((exp_code != 3'b000) ? 1 : 0);

      chk({tag, "_frames_done"}, 32'(frames_done), 32'(exp_f));
      chk({tag, "_err_code"},    32'(err_code), 32'(exp_code));
      chk({tag, "_done_irqs"},   32'(n_done), (exp_code == 3'b000) ? 32'd1 : 32'd0);
      chk({tag, "_err_irqs"},    32'(n_err),  (exp_code != 3'b000) ? 32'd1 : 32'd0);
      chk({tag, "_rst_pulses"},  32'(n_rstp), 32'(exp_launch));
      chk({tag, "_rd_pulses"},   32'(n_rd), rd ? 32'(exp_launch) : 32'd0);
      chk({tag, "_wr_pulses"},   32'(n_wr), wr ? 32'(exp_launch) : 32'd0);
      chk({tag, "_launch_lat"},  32'(first_launch_cyc - s_cyc), 32'(RST_CYCLES + 1));
      foreach (rd_addr_q[i]) chk({tag, "_rd_addr"}, rd_addr_q[i], (i % 2) ? s1 : s0);
      foreach (wr_addr_q[i]) chk({tag, "_wr_addr"}, wr_addr_q[i], (i % 2) ? d1 : d0);
      if (nf) chk({tag, "_start_win_lat"}, 32'(irq_cyc - launch_cyc), 32'(START_WIN + 1));
      if (nr) chk({tag, "_timeout_lat"},   32'(irq_cyc - launch_cyc), 32'(TIMEOUT) + 32'd2);
   endtask

   initial begin
      logic [3:0] resp_tbl [4];
      bit         rd_r, wr_r;
      int         cnt_r, inj_r;
      resp_tbl[0] = 4'b1000; resp_tbl[1] = 4'b1100; resp_tbl[2] = 4'b0010; resp_tbl[3] = 4'b0011;

      axi_resetn = 1'b0;
      cfg_rd_en = 1'b0; cfg_wr_en = 1'b0;
      cfg_src_base0 = '0; cfg_src_base1 = '0; cfg_dst_base0 = '0; cfg_dst_base1 = '0;
      cfg_frame_count = '0;
      start = 1'b0; abort = 1'b0;
      dif.read_idle = 1'b1; dif.write_idle = 1'b1; dif.rw_resp = 4'b0000;
      never_fall = 1'b0; never_rise = 1'b0; pend = 1'b0; busy_left = 0;
      inj_frame = -1; abort_frame = -1; inj_val = 4'b0000; prev_rstn = 1'b1;
      clear_obs();

      repeat (3) tick();
      chk("rst_busy",       32'(busy), 32'd0);
      chk("rst_done_irq",   32'(done_irq), 32'd0);
      chk("rst_err_irq",    32'(err_irq), 32'd0);
      chk("rst_rd_active",  32'(dif.read_active), 32'd0);
      chk("rst_wr_active",  32'(dif.write_active), 32'd0);
      chk("rst_dma_resetn", 32'(dif.dma_resetn), 32'd0);
      chk("rst_rd_addr",    dif.read_address, 32'd0);
      chk("rst_wr_addr",    dif.write_address, 32'd0);
      chk("rst_frames",     32'(frames_done), 32'd0);
      chk("rst_err_code",   32'(err_code), 32'd0);
      axi_resetn = 1'b1;
      tick();
      chk("rel_dma_resetn", 32'(dif.dma_resetn), 32'd1);

      run(1'b1, 1'b1, 3, -1, -1, 4'b0000, 1'b0, 1'b0, "pingpong3");
      run(1'b1, 1'b0, 1, -1,  0, 4'b1000, 1'b0, 1'b0, "rd_slverr");
      run(1'b1, 1'b1, 0,  1, -1, 4'b0000, 1'b0, 1'b0, "cont_abort");
      run(1'b1, 1'b1, 2, -1, -1, 4'b0000, 1'b0, 1'b1, "timeout");
      run(1'b0, 1'b1, 2, -1, -1, 4'b0000, 1'b1, 1'b0, "no_start");

      // start with no channel enabled does nothing
      clear_obs();
      cfg_rd_en = 1'b0; cfg_wr_en = 1'b0; cfg_frame_count = 16'd1;
      start = 1'b1;
      repeat (3) tick();
      chk("noen_busy",   32'(busy), 32'd0);
      chk("noen_rstp",   32'(n_rstp), 32'd0);

      // reset in the middle of a frame
      clear_obs();
      never_fall = 1'b0; never_rise = 1'b0; inj_frame = -1; abort_frame = -1;
      cfg_rd_en = 1'b1; cfg_wr_en = 1'b1; cfg_frame_count = 16'd2;
      cfg_src_base0 = 32'h1000_0000; cfg_dst_base0 = 32'h2000_0000;
      start = 1'b1;
      for (int i = 0; i < 40 && busy_left < 3; i++) tick();
      chk("mid_in_frame", 32'(busy_left >= 3), 32'd1);
      axi_resetn = 1'b0;
      tick();
      chk("mid_busy",       32'(busy), 32'd0);
      chk("mid_dma_resetn", 32'(dif.dma_resetn), 32'd0);
      chk("mid_rd_addr",    dif.read_address, 32'd0);
      chk("mid_frames",     32'(frames_done), 32'd0);
      chk("mid_err_code",   32'(err_code), 32'd0);
      axi_resetn = 1'b1;
      tick();
      chk("mid_rel_rstn",   32'(dif.dma_resetn), 32'd1);
      chk("mid_no_irq",     32'(n_done + n_err), 32'd0);
      run(1'b1, 1'b1, 2, -1, -1, 4'b0000, 1'b0, 1'b0, "after_rst");

      for (int r = 0; r < 5; r++) begin
         rd_r  = 1'($urandom_range(0, 1));
         wr_r  = rd_r ? 1'($urandom_range(0, 1)) : 1'b1;
         cnt_r = $urandom_range(1, 4);
         inj_r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, cnt_r - 1) : -1;
         run(rd_r, wr_r, cnt_r, -1, inj_r, resp_tbl[$urandom_range(0, 3)], 1'b0, 1'b0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
